change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
- REQ-001 SHALL have parameter PULSE_GAP, default 2: idle cycles between consecutive coin pulses (1..15).
- REQ-002 SHALL have parameters INIT_DOLLAR, INIT_QUARTER, INIT_DIME, INIT_NICKEL, default 15 each: coin counts loaded at reset and refill.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
- REQ-005 SHALL have port req_valid, input, 1: change request present.
- REQ-006 SHALL have port req_amount, input, 9: change owed in cents, 0..511.
- REQ-007 SHALL have port req_ready, output, 1: high only in IDLE.
- REQ-008 SHALL have ports disp_dollar, disp_quarter, disp_dime, disp_nickel, output, 1 each: one-cycle eject pulses.
- REQ-009 SHALL have port done, output, 1: one-cycle pulse ending a request.
- REQ-010 SHALL have port shortfall, output, 1: valid with done; change could not be fully paid.
- REQ-011 SHALL have port remaining, output, 9: cents still owed; holds its value after done until the next accept.
- REQ-012 SHALL have port refill, input, 1: reload inventory to INIT_* values; ignored unless in IDLE.

Function
- REQ-013 SHALL implement states IDLE, SELECT, PULSE, GAP, FINISH.
- REQ-014 SHALL accept on req_valid && req_ready: latch req_amount into remaining; IDLE->SELECT.
- REQ-015 SHALL, in SELECT, pick the largest coin with value <= remaining and inventory > 0 (100, 25, 10, 5 priority).
- REQ-016 SHALL go SELECT->FINISH when remaining == 0 or no coin qualifies; otherwise SELECT->PULSE.
- REQ-017 SHALL, in PULSE, assert exactly one disp_* for one cycle, subtract its value from remaining, decrement its inventory; PULSE->GAP.
- REQ-018 SHALL hold GAP exactly PULSE_GAP cycles, then GAP->SELECT.
- REQ-019 SHALL, in FINISH, pulse done for one cycle with shortfall = (remaining != 0); FINISH->IDLE.
- REQ-020 SHALL make the first coin pulse appear 2 cycles after the accept edge and space coin pulses PULSE_GAP+2 cycles apart.
- REQ-021 SHALL treat req_amount 0 as immediate FINISH: done 2 cycles after accept, shortfall 0, no coin pulse.
- REQ-022 SHALL leave residues not divisible by 5 in remaining and report shortfall.
- REQ-023 SHALL ignore req_valid while not IDLE; requests are not queued.
- REQ-024 SHALL saturate inventory decrement at 0; remaining SHALL never underflow.
- REQ-025 SHALL give accept priority over refill when both occur in the same IDLE cycle; refill is lost.

Reset
- REQ-026 SHALL, on rst_n low, immediately enter IDLE: req_ready 1; all disp_*, done, shortfall 0; remaining 0; inventory INIT_*.
- REQ-027 SHALL abort any request in progress on reset, with no done pulse.

Configuration
- REQ-028 SHALL, with CHANGE_INVENTORY_EN defined, track 4-bit per-coin inventory as specified and honour refill.
- REQ-029 SHALL, without CHANGE_INVENTORY_EN, treat every inventory as unlimited, ignore refill, and report shortfall only for 5-cent residues.

Structure
- REQ-030 SHALL place coin value constants (5, 10, 25, 100), the state enum typedef, and the coin-select enum in shared package change_pkg.
- REQ-031 SHALL implement the largest-coin choice in combinational sub-module coin_selector (inputs remaining and inventory-nonzero flags; outputs coin enum and valid).

Verification
- REQ-032 SHALL cover: 165 cents, full inventory -> dollar, quarter, quarter, dime, nickel; done=1, shortfall=0, remaining=0.
- REQ-033 SHALL cover: 50 cents with quarter inventory 1 -> quarter, dime, dime, nickel; shortfall=0.
- REQ-034 SHALL cover: 7 cents -> nickel; done with shortfall=1, remaining=2.
- REQ-035 SHALL cover: 0 cents -> no pulse; done 2 cycles after accept, shortfall=0.
- REQ-036 SHALL cover: 300 cents, rst_n low after the first dollar pulse -> outputs at reset values, no done; inventory back to 15.
- REQ-037 SHALL cover: req_valid held during a 100-cent payout -> req_ready=0 throughout; one payout only; pulse spacing PULSE_GAP+2 cycles.

Source files
------------

// File: rtl/change_pkg.sv
`default_nettype none
// change_pkg: coin values, FSM state encoding and coin-select encoding shared by the change dispenser.
package change_pkg;

   localparam logic [8:0] VAL_DOLLAR  = 9'd100;
   localparam logic [8:0] VAL_QUARTER = 9'd25;
   localparam logic [8:0] VAL_DIME    = 9'd10;
   localparam logic [8:0] VAL_NICKEL  = 9'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Encoding doubles as the index into per-coin flag vectors and inventory arrays.
   typedef enum logic [1:0] {
      COIN_DOLLAR  = 2'd0,
      COIN_QUARTER = 2'd1,
      COIN_DIME    = 2'd2,
      COIN_NICKEL  = 2'd3
   } coin_t;

   function automatic logic [8:0] coin_value(input coin_t c);
      case (c)
         COIN_DOLLAR:  return VAL_DOLLAR;
         COIN_QUARTER: return VAL_QUARTER;
         COIN_DIME:    return VAL_DIME;
         default:      return VAL_NICKEL;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/coin_selector.sv
`default_nettype none
// coin_selector: combinational pick of the largest coin that fits in remaining and is in stock.
module coin_selector
   import change_pkg::*;
(
   input  logic [8:0] remaining,
   input  logic [3:0] avail,
   output coin_t      coin,
   output logic       valid
);

   always_comb begin
      coin  = COIN_NICKEL;
      valid = 1'b0;
      if (remaining >= VAL_DOLLAR && avail[COIN_DOLLAR]) begin
         coin  = COIN_DOLLAR;
         valid = 1'b1;
      end else if (remaining >= VAL_QUARTER && avail[COIN_QUARTER]) begin
         coin  = COIN_QUARTER;
         valid = 1'b1;
      end else if (remaining >= VAL_DIME && avail[COIN_DIME]) begin
         coin  = COIN_DIME;
         valid = 1'b1;
      end else if (remaining >= VAL_NICKEL && avail[COIN_NICKEL]) begin
         coin  = COIN_NICKEL;
         valid = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// change_dispenser: greedy coin payout FSM with registered, PULSE_GAP-paced eject pulses.
// Define CHANGE_INVENTORY_EN for 4-bit per-coin inventory with refill; otherwise stock is unlimited.
module change_dispenser
   import change_pkg::*;
#(
   parameter int PULSE_GAP    = 2,
   parameter int INIT_DOLLAR  = 15,
   parameter int INIT_QUARTER = 15,
   parameter int INIT_DIME    = 15,
   parameter int INIT_NICKEL  = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [8:0] req_amount,
   output logic       req_ready,
   output logic       disp_dollar,
   output logic       disp_quarter,
   output logic       disp_dime,
   output logic       disp_nickel,
   output logic       done,
   output logic       shortfall,
   output logic [8:0] remaining,
   input  logic       refill
);

   state_t      state;
   state_t      state_next;
   coin_t       coin_q;
   coin_t       sel_coin;
   logic        sel_valid;
   logic [3:0]  avail;
   logic [3:0]  gap_cnt;
   logic [8:0]  coin_val;

   assign req_ready = (state == ST_IDLE);
   assign coin_val  = coin_value(coin_q);

   coin_selector u_coin_selector (
      .remaining (remaining),
      .avail     (avail),
      .coin      (sel_coin),
      .valid     (sel_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (req_valid) state_next = ST_SELECT;
         ST_SELECT: begin
            if (remaining == 9'd0 || !sel_valid) state_next = ST_FINISH;
            else                                 state_next = ST_PULSE;
         end
         ST_PULSE:  state_next = ST_GAP;
         ST_GAP:    if (gap_cnt == 4'(PULSE_GAP - 1)) state_next = ST_SELECT;
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered on the edge leaving a state, which sets the 2-cycle accept-to-pulse latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining    <= '0;
         coin_q       <= COIN_DOLLAR;
         gap_cnt      <= '0;
         disp_dollar  <= 1'b0;
         disp_quarter <= 1'b0;
         disp_dime    <= 1'b0;
         disp_nickel  <= 1'b0;
         done         <= 1'b0;
         shortfall    <= 1'b0;
      end else begin
         disp_dollar  <= 1'b0;
         disp_quarter <= 1'b0;
         disp_dime    <= 1'b0;
         disp_nickel  <= 1'b0;
         done         <= 1'b0;
         shortfall    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) remaining <= req_amount;
            end
            ST_SELECT: begin
               coin_q  <= sel_coin;
               gap_cnt <= '0;
            end
            ST_PULSE: begin
               case (coin_q)
                  COIN_DOLLAR:  disp_dollar  <= 1'b1;
                  COIN_QUARTER: disp_quarter <= 1'b1;
                  COIN_DIME:    disp_dime    <= 1'b1;
                  default:      disp_nickel  <= 1'b1;
               endcase
               remaining <= (remaining >= coin_val) ? (remaining - coin_val) : 9'd0;
            end
            ST_GAP: begin
               gap_cnt <= gap_cnt + 4'd1;
            end
            ST_FINISH: begin
               done      <= 1'b1;
               shortfall <= (remaining != 9'd0);
            end
            default: ;
         endcase
      end
   end

`ifdef CHANGE_INVENTORY_EN
   localparam logic [3:0] INV_INIT [4] = '{4'(INIT_DOLLAR), 4'(INIT_QUARTER),
                                           4'(INIT_DIME),   4'(INIT_NICKEL)};
   logic [3:0] inv [4];

   // A same-cycle accept wins over refill, so refill only reloads when no request is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) inv[i] <= INV_INIT[i];
      end else if (state == ST_IDLE && refill && !req_valid) begin
         for (int i = 0; i < 4; i++) inv[i] <= INV_INIT[i];
      end else if (state == ST_PULSE && inv[coin_q] != 4'd0) begin
         inv[coin_q] <= inv[coin_q] - 4'd1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_avail
      assign avail[g] = (inv[g] != 4'd0);
   end
`else
   logic unused_refill;
   assign unused_refill = refill;
   assign avail         = 4'b1111;
`endif

endmodule
`default_nettype wire
